// File: rtl/passcode_lock_pkg.sv
// Shared types for the passcode lock: FSM state encoding and keypad codes.
package passcode_lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROGRAM = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_e;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Lockout interval timer: i_start arms it, o_done pulses for one cycle on the
// last cycle of a CYCLES-long interval, after which it idles until re-armed.
module lockout_timer #(
    parameter int CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_done
);

    localparam int            TW   = $clog2(CYCLES);
    localparam logic [TW-1:0] LAST = TW'(CYCLES - 1);

    logic          r_run;
    logic [TW-1:0] r_cnt;

    // o_done is high while the counter sits at CYCLES-1, so the consumer
    // leaves its waiting state exactly CYCLES edges after the arming edge.
    assign o_done = r_run && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (o_done) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (r_run) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/passcode_lock.sv
// Keypad passcode lock: BCD entry, compare, failed-try lockout.
// Define PASSCODE_LOCK_PROG_EN to allow reprogramming the code from OPEN.
module passcode_lock
    import passcode_lock_pkg::*;
#(
    parameter int                      CODE_LEN       = 6,
    parameter int                      MAX_TRIES      = 3,
    parameter int                      LOCKOUT_CYCLES = 1000,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               key_valid,
    input  logic [3:0]                         key_code,
    output logic [2:0]                         state,
    output logic [CODE_LEN-1:0]                digit_led,
    output logic                               unlocked,
    output logic                               alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

    localparam int            CW      = $clog2(CODE_LEN + 1);
    localparam int            FW      = $clog2(MAX_TRIES + 1);
    localparam int            BW      = 4 * CODE_LEN;
    localparam logic [CW-1:0] LEN_C   = CW'(CODE_LEN);
    localparam logic [FW-1:0] TRIES_C = FW'(MAX_TRIES);

    state_e        r_state;
    state_e        w_next;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_buf;
    logic [BW-1:0] w_stored;
    logic [FW-1:0] r_fail;
    logic [FW-1:0] w_fail_inc;
    logic          w_star;
    logic          w_hash;
    logic          w_digit;
    logic          w_full;
    logic          w_match;
    logic          w_collect;
    logic          w_clear;
    logic          w_tmr_start;
    logic          w_tmr_done;

    // key_valid is a one-cycle strobe with no back-pressure: a key is consumed
    // on every edge where key_valid is high, back-to-back strobes included.
    assign w_star  = key_valid && (key_code == KEY_STAR);
    assign w_hash  = key_valid && (key_code == KEY_HASH);
    assign w_digit = key_valid && is_digit(key_code);

    assign w_full      = (r_count == LEN_C);
    assign w_match     = w_full && (r_buf == w_stored);
    assign w_fail_inc  = r_fail + FW'(1);
    assign w_collect   = ((r_state == ST_ENTRY) || (r_state == ST_PROGRAM)) && w_digit && !w_full;
    assign w_clear     = ((r_state == ST_LOCKED) && w_star) ||
                         ((r_state == ST_OPEN) && (w_next == ST_PROGRAM));
    assign w_tmr_start = (r_state != ST_LOCKOUT) && (w_next == ST_LOCKOUT);

    lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_start (w_tmr_start),
        .o_done  (w_tmr_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOCKED;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_LOCKED: begin
                if (w_star) w_next = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (w_star) begin
                    w_next = ST_LOCKED;
                end else if (w_hash) begin
                    if (w_match)                    w_next = ST_OPEN;
                    else if (w_fail_inc == TRIES_C) w_next = ST_LOCKOUT;
                    else                            w_next = ST_LOCKED;
                end
            end
            ST_OPEN: begin
                if (w_star) w_next = ST_LOCKED;
`ifdef PASSCODE_LOCK_PROG_EN
                else if (w_hash) w_next = ST_PROGRAM;
`endif
            end
            ST_PROGRAM: begin
                if (w_star || w_hash) w_next = ST_OPEN;
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) w_next = ST_LOCKED;
            end
            default: w_next = ST_LOCKED;
        endcase
    end

    always_comb begin
        digit_led = '0;
        unlocked  = (r_state == ST_OPEN);
        alarm     = (r_state == ST_LOCKOUT);
        if ((r_state == ST_ENTRY) || (r_state == ST_PROGRAM)) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                digit_led[i] = (int'(r_count) > i);
            end
        end
    end

    assign state      = r_state;
    assign fail_count = r_fail;

    // First digit entered ends up in the most significant nibble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_buf   <= '0;
            r_fail  <= '0;
        end else begin
            if (w_clear) begin
                r_count <= '0;
                r_buf   <= '0;
            end else if (w_collect) begin
                r_buf   <= {r_buf[BW-5:0], key_code};
                r_count <= r_count + CW'(1);
            end
            if ((r_state == ST_ENTRY) && w_hash) begin
                r_fail <= w_match ? '0 : w_fail_inc;
            end else if ((r_state == ST_LOCKOUT) && w_tmr_done) begin
                r_fail <= '0;
            end
        end
    end

`ifdef PASSCODE_LOCK_PROG_EN
    logic [BW-1:0] r_code;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code <= DEFAULT_CODE;
        end else if ((r_state == ST_PROGRAM) && w_hash && w_full) begin
            r_code <= r_buf;
        end
    end

    assign w_stored = r_code;
`else
    assign w_stored = DEFAULT_CODE;
`endif

endmodule

// File: tb/tb_passcode_lock.sv
// Directed, table-driven bench for passcode_lock (CODE_LEN=6, code 123456,
// MAX_TRIES=3, LOCKOUT_CYCLES=1000); PROGRAM checks under PASSCODE_LOCK_PROG_EN.
module tb_passcode_lock;

    localparam logic [2:0] S_LOCKED  = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_PROGRAM = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam logic [3:0] K_STAR    = 4'hA;
    localparam logic [3:0] K_HASH    = 4'hB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [2:0] state;
    logic [5:0] digit_led;
    logic       unlocked;
    logic       alarm;
    logic [1:0] fail_count;

    int total = 0;
    int bad   = 0;
    int vec_n = 0;

    typedef struct {
        logic       kv;
        logic [3:0] key;
        logic [2:0] st;
        logic [5:0] led;
        logic       unl;
        logic       al;
        logic [1:0] fc;
    } vec_t;

    vec_t vq[$];

    passcode_lock #(
        .CODE_LEN       (6),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (1000),
        .DEFAULT_CODE   (24'h123456)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .state      (state),
        .digit_led  (digit_led),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic apply(input logic kv, input logic [3:0] key);
        @(negedge clk);
        key_valid = kv;
        key_code  = key;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic do_reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [2:0] st, input logic [5:0] led,
                             input logic unl, input logic al, input logic [1:0] fc);
        check_val(name, {19'd0, state, digit_led, unlocked, alarm, fail_count},
                        {19'd0, st, led, unl, al, fc});
    endtask

    function automatic logic [5:0] therm(input int k);
        logic [5:0] t;
        t = '0;
        for (int i = 0; i < 6; i++) t[i] = (k > i);
        return t;
    endfunction

    function automatic void add(input logic kv, input logic [3:0] key, input logic [2:0] st,
                                input logic [5:0] led, input logic unl, input logic al,
                                input logic [1:0] fc);
        vec_t v;
        v.kv = kv; v.key = key; v.st = st; v.led = led; v.unl = unl; v.al = al; v.fc = fc;
        vq.push_back(v);
    endfunction

    // star then n digits of code (MS nibble first) from start_st; hash is added by caller
    function automatic void add_entry(input logic [2:0] entry_st, input logic [23:0] code,
                                      input int n, input logic [1:0] fc);
        logic [23:0] c;
        c = code;
        add(1'b1, K_STAR, entry_st, 6'b0, 1'b0, 1'b0, fc);
        for (int i = 0; i < n; i++) begin
            add(1'b1, c[23:20], entry_st, therm((i + 1 > 6) ? 6 : i + 1), 1'b0, 1'b0, fc);
            c = c << 4;
        end
    endfunction

    task automatic run_vecs();
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].kv, vq[i].key);
            check_out($sformatf("vec%0d", vec_n), vq[i].st, vq[i].led, vq[i].unl, vq[i].al, vq[i].fc);
            vec_n++;
        end
        vq.delete();
    endtask

    task automatic add_three_wrong();
        add_entry(S_ENTRY, 24'h123457, 6, 2'd0);
        add(1'b1, K_HASH, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd1);
        add_entry(S_ENTRY, 24'h123457, 6, 2'd1);
        add(1'b1, K_HASH, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd2);
        add_entry(S_ENTRY, 24'h123457, 6, 2'd2);
        add(1'b1, K_HASH, S_LOCKOUT, 6'b0, 1'b0, 1'b1, 2'd3);
    endtask

    task automatic add_open_default(input logic [1:0] fc);
        add_entry(S_ENTRY, 24'h123456, 6, fc);
        add(1'b1, K_HASH, S_OPEN, 6'b0, 1'b1, 1'b0, 2'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int alarm_cycles;
        int guard;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        release_reset();

        // cancel after three digits, short entry, ignored keys, good code with extra digit
        add(1'b1, 4'h1,   S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, K_STAR, S_ENTRY,  6'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h1,   S_ENTRY,  6'b000001, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h2,   S_ENTRY,  6'b000011, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h3,   S_ENTRY,  6'b000111, 1'b0, 1'b0, 2'd0);
        add(1'b1, K_STAR, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        add_entry(S_ENTRY, 24'h120000, 2, 2'd0);
        add(1'b1, K_HASH, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd1);
        add(1'b1, 4'hC,   S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd1);
        add(1'b0, K_STAR, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd1);
        add_entry(S_ENTRY, 24'h123456, 6, 2'd1);
        add(1'b1, 4'hE,   S_ENTRY,  6'b111111, 1'b0, 1'b0, 2'd1);
        add(1'b1, 4'h7,   S_ENTRY,  6'b111111, 1'b0, 1'b0, 2'd1);
        add(1'b1, K_HASH, S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, K_STAR, S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'hD,   S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'h5,   S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, K_STAR, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        add_three_wrong();
        run_vecs();

        // lockout: keys ignored, alarm held for exactly 1000 cycles
        alarm_cycles = 1;
        apply(1'b1, K_STAR);
        check_out("lockout_star", S_LOCKOUT, 6'b0, 1'b0, 1'b1, 2'd3);
        if (alarm) alarm_cycles++;
        apply(1'b1, 4'h1);
        check_out("lockout_digit", S_LOCKOUT, 6'b0, 1'b0, 1'b1, 2'd3);
        if (alarm) alarm_cycles++;
        apply(1'b1, K_HASH);
        check_out("lockout_hash", S_LOCKOUT, 6'b0, 1'b0, 1'b1, 2'd3);
        if (alarm) alarm_cycles++;
        guard = 0;
        while (guard < 2000) begin
            @(posedge clk);
            #1;
            if (!alarm) break;
            alarm_cycles++;
            guard++;
        end
        check_val("lockout_bound", guard < 2000, 1);
        check_val("alarm_cycles", alarm_cycles, 1000);
        check_out("lockout_exit", S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);

        // correct code still opens after lockout
        add_open_default(2'd0);
`ifdef PASSCODE_LOCK_PROG_EN
        // reprogram to 654321, relock, reopen with new code, old code fails
        add(1'b1, K_HASH, S_PROGRAM, 6'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h6,   S_PROGRAM, 6'b000001, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h5,   S_PROGRAM, 6'b000011, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h4,   S_PROGRAM, 6'b000111, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h3,   S_PROGRAM, 6'b001111, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h2,   S_PROGRAM, 6'b011111, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h1,   S_PROGRAM, 6'b111111, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h9,   S_PROGRAM, 6'b111111, 1'b0, 1'b0, 2'd0);
        add(1'b1, K_HASH, S_OPEN,    6'b0, 1'b1, 1'b0, 2'd0);
        // short program attempt leaves the code alone
        add(1'b1, K_HASH, S_PROGRAM, 6'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h7,   S_PROGRAM, 6'b000001, 1'b0, 1'b0, 2'd0);
        add(1'b1, K_HASH, S_OPEN,    6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, K_STAR, S_LOCKED,  6'b0, 1'b0, 1'b0, 2'd0);
        add_entry(S_ENTRY, 24'h654321, 6, 2'd0);
        add(1'b1, K_HASH, S_OPEN,    6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, K_STAR, S_LOCKED,  6'b0, 1'b0, 1'b0, 2'd0);
        add_entry(S_ENTRY, 24'h123456, 6, 2'd0);
        add(1'b1, K_HASH, S_LOCKED,  6'b0, 1'b0, 1'b0, 2'd1);
        add_entry(S_ENTRY, 24'h654321, 6, 2'd1);
        add(1'b1, K_HASH, S_OPEN,    6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, K_HASH, S_PROGRAM, 6'b0, 1'b0, 1'b0, 2'd0);
        add(1'b1, 4'h9,   S_PROGRAM, 6'b000001, 1'b0, 1'b0, 2'd0);
        run_vecs();
        do_reset_pulse();
        check_out("reset_in_program", S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        release_reset();
        add_open_default(2'd0);
`else
        // without programming support, hash in OPEN does nothing
        add(1'b1, K_HASH, S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 4'h3,   S_OPEN,   6'b0, 1'b1, 1'b0, 2'd0);
`endif
        add(1'b1, K_STAR, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        add_three_wrong();
        run_vecs();

        // reset in the middle of lockout
        repeat (5) apply(1'b0, 4'h0);
        check_out("lockout_hold", S_LOCKOUT, 6'b0, 1'b0, 1'b1, 2'd3);
        do_reset_pulse();
        check_out("reset_in_lockout", S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        release_reset();
        add_open_default(2'd0);
        add(1'b1, K_STAR, S_LOCKED, 6'b0, 1'b0, 1'b0, 2'd0);
        run_vecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
